// File: rtl/alu_result_fifo.sv
// Result stage behind the 4-bit signed ALU: tags each result with zero/neg/logic flags
// and buffers it in a first-word-fall-through FIFO. Define ALU_RES_STATS_EN for push statistics.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    in_y,
  input  logic [3:0]    in_sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [5:0]    out_y,
  output logic [3:0]    out_sel,
  output logic          out_zero,
  output logic          out_neg,
  output logic          out_logic,
`ifdef ALU_RES_STATS_EN
  output logic [7:0]    logic_cnt,
  output logic [7:0]    arith_cnt,
`endif
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [5:0] y;
    logic [3:0] sel;
    logic       zero;
    logic       neg;
    logic       is_logic;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wrptr;
  logic [AW-1:0] rdptr;
  logic          push;
  logic          pop;

  // in_ready looks only at count, so a full FIFO never takes a push even while popping
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrptr <= '0;
      rdptr <= '0;
      count <= '0;
    end else begin
      if (push) wrptr <= wrptr + AW'(1);
      if (pop)  rdptr <= rdptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; flags are computed once, at push time
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wrptr] <= {in_y, in_sel, (in_y == 6'd0), in_y[5], in_sel[3]};
    end
  end

  always_comb begin
    head      = mem[rdptr];
    out_y     = 6'd0;
    out_sel   = 4'd0;
    out_zero  = 1'b0;
    out_neg   = 1'b0;
    out_logic = 1'b0;
    if (out_valid) begin
      out_y     = head.y;
      out_sel   = head.sel;
      out_zero  = head.zero;
      out_neg   = head.neg;
      out_logic = head.is_logic;
    end
  end

`ifdef ALU_RES_STATS_EN
  // Saturating tallies of accepted pushes split by operation class
  always_ff @(posedge clk) begin
    if (rst) begin
      logic_cnt <= 8'd0;
      arith_cnt <= 8'd0;
    end else if (push) begin
      if (in_sel[3]) begin
        if (logic_cnt != 8'hFF) logic_cnt <= logic_cnt + 8'd1;
      end else begin
        if (arith_cnt != 8'hFF) arith_cnt <= arith_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
